// File: rtl/gate_tt_checker.sv
// gate_tt_checker
// ----------------
// Truth-table sequencer and checker for a 2-input combinational gate.
// It drives the fixed vector sequence {a,b} = 00, 11, 01, 10 into the device
// under test. Each vector is held for HOLD cycles. The device output is
// sampled on the last cycle of each hold and compared with TT[{a,b}].
// When the run ends, the block reports a per-vector failure mask, an error
// count and a pass flag.
//
// Parameters
//   HOLD : cycles each vector is held (1..255)
//   TT   : expected truth table, expected output = TT[{a,b}]
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   begin a run (accepted in IDLE or DONE only)
//   a_o      out  vector bit a to the device under test
//   b_o      out  vector bit b to the device under test
//   o_i      in   device-under-test output
//   busy     out  high while vectors are being applied
//   done     out  high from run completion until the next accepted start
//   pass     out  valid with done, high when no vector mismatched
//   err_cnt  out  number of mismatching vectors (0..4)
//   fail_vec out  bit i set when vector index i mismatched
module gate_tt_checker #(
    parameter int unsigned HOLD = 10,
    parameter logic [3:0]  TT   = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    input  logic       o_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_vec
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     state_q;
    logic [1:0] idx_q;
    logic [7:0] cnt_q;
    logic       a_q;
    logic       b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [2:0] err_q;
    logic [3:0] fail_q;

    // Vector table: index -> {a,b}
    function automatic logic [1:0] vec_ab(input logic [1:0] idx);
        case (idx)
            2'd0:    vec_ab = 2'b00;
            2'd1:    vec_ab = 2'b11;
            2'd2:    vec_ab = 2'b01;
            default: vec_ab = 2'b10;
        endcase
    endfunction

    // Result update for the vector currently on the bus. a_q/b_q always hold
    // vector[idx_q] while in APPLY, so they index the truth table directly.
    logic       mismatch;
    logic [2:0] err_d;
    logic [3:0] fail_d;

    always_comb begin
        mismatch        = (o_i != TT[{a_q, b_q}]);
        err_d           = err_q + {2'b00, mismatch};
        fail_d          = fail_q;
        fail_d[idx_q]   = fail_q[idx_q] | mismatch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_APPLY;
                        idx_q   <= 2'd0;
                        cnt_q   <= 8'd0;
                        {a_q, b_q} <= vec_ab(2'd0);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= 3'd0;
                        fail_q  <= 4'd0;
                    end
                end
                S_APPLY: begin
                    // start is deliberately ignored here
                    if (cnt_q == HOLD_LAST) begin
                        err_q  <= err_d;
                        fail_q <= fail_d;
                        if (idx_q == 2'd3) begin
                            state_q <= S_DONE;
                            cnt_q   <= 8'd0;
                            a_q     <= 1'b0;
                            b_q     <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == 3'd0);
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            cnt_q   <= 8'd0;
                            {a_q, b_q} <= vec_ab(idx_q + 2'd1);
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    a_q     <= 1'b0;
                    b_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_o      = a_q;
    assign b_o      = b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_vec = fail_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Testbench for gate_tt_checker. Two instances (HOLD=10 and HOLD=1, both
// expecting AND) each drive a modelled device whose truth table is chosen
// per run. The expected outputs come from a reference model that works
// directly from the vector list and the truth tables.
module tb_gate_tt_checker;

    localparam logic [3:0] TT_AND = 4'b1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // HOLD=10 instance
    logic       start10 = 1'b0;
    logic       a10, b10, o10, busy10, done10, pass10;
    logic [2:0] err10;
    logic [3:0] fail10;
    logic [3:0] dev10 = TT_AND;
    assign o10 = dev10[{a10, b10}];

    gate_tt_checker #(.HOLD(10), .TT(TT_AND)) dut10 (
        .clk(clk), .rst(rst), .start(start10), .a_o(a10), .b_o(b10),
        .o_i(o10), .busy(busy10), .done(done10), .pass(pass10),
        .err_cnt(err10), .fail_vec(fail10)
    );

    // HOLD=1 instance
    logic       start1 = 1'b0;
    logic       a1, b1, o1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] fail1;
    logic [3:0] dev1 = TT_AND;
    assign o1 = dev1[{a1, b1}];

    gate_tt_checker #(.HOLD(1), .TT(TT_AND)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_o(a1), .b_o(b1),
        .o_i(o1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_vec(fail1)
    );

    // Select which instance the run task is observing
    logic       sel = 1'b0;
    logic       a_s, b_s, busy_s, done_s, pass_s;
    logic [2:0] err_s;
    logic [3:0] fail_s;
    assign a_s    = sel ? a1    : a10;
    assign b_s    = sel ? b1    : b10;
    assign busy_s = sel ? busy1 : busy10;
    assign done_s = sel ? done1 : done10;
    assign pass_s = sel ? pass1 : pass10;
    assign err_s  = sel ? err1  : err10;
    assign fail_s = sel ? fail1 : fail10;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] vec_list [4] = '{2'b00, 2'b11, 2'b01, 2'b10};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v; else start10 = v;
    endtask

    // One run on the selected instance, starting from a negedge.
    // mid_k : cycle index at which start is pulsed again (-1 = none)
    // rst_k : cycle index at which rst is asserted asynchronously (-1 = none)
    task automatic run(input logic s, input logic [3:0] dtt, input int mid_k, input int rst_k);
        int h;
        int ec;
        logic [3:0] ef;
        logic [3:0] pm;
        sel = s;
        h = s ? 1 : 10;
        if (s) dev1 = dtt; else dev10 = dtt;
        // vector j fails when the device disagrees with AND at that vector
        for (int j = 0; j < 4; j++)
            ef[j] = (dtt[vec_list[j]] != TT_AND[vec_list[j]]);
        ec = $countones(ef);
        #1;
        set_start(1'b1);
        @(negedge clk);
        for (int k = 0; k < 4 * h; k++) begin
            if (k == rst_k) begin
                set_start(1'b0);
                #2 rst = 1'b1;
                #1;
                chk("rst_async_outs", {1'b0, a_s, b_s, busy_s, done_s, pass_s, 2'b00}, 8'h00);
                chk("rst_async_res", {1'b0, err_s, fail_s}, 8'h00);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk("idle_after_rst", {3'b000, a_s, b_s, busy_s, done_s, pass_s}, 8'h00);
                end
                $display("run sel=%0d dev=%b reset at cycle %0d", s, dtt, k);
                return;
            end
            // vectors whose sample edge has already passed
            for (int j = 0; j < 4; j++) pm[j] = ((j + 1) * h <= k);
            chk("ab",        {6'd0, a_s, b_s}, {6'd0, vec_list[k / h]});
            chk("busy_done", {6'd0, busy_s, done_s}, 8'h02);
            chk("err_run",   {5'd0, err_s}, 8'($countones(ef & pm)));
            chk("fail_run",  {4'd0, fail_s}, {4'd0, ef & pm});
            chk("pass_run",  {7'd0, pass_s}, 8'h00);
            set_start(k == mid_k);
            @(negedge clk);
        end
        set_start(1'b0);
        chk("done_end",  {6'd0, busy_s, done_s}, 8'h01);
        chk("ab_end",    {6'd0, a_s, b_s}, 8'h00);
        chk("err_end",   {5'd0, err_s}, 8'(ec));
        chk("fail_end",  {4'd0, fail_s}, {4'd0, ef});
        chk("pass_end",  {7'd0, pass_s}, {7'd0, ec == 0});
        $display("run sel=%0d dev=%b err=%0d fail=%b pass=%0d", s, dtt, err_s, fail_s, pass_s);
    endtask

    initial begin
        int s_r;
        int h_r;
        int mid;
        @(negedge clk);
        chk("reset_outs10", {3'b000, a10, b10, busy10, done10, pass10}, 8'h00);
        chk("reset_res10",  {1'b0, err10, fail10}, 8'h00);
        chk("reset_outs1",  {3'b000, a1, b1, busy1, done1, pass1}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", {3'b000, a10, b10, busy10, done10, pass10}, 8'h00);

        run(1'b0, 4'b1000, -1, -1);   // correct AND device
        run(1'b0, 4'b0000, -1, -1);   // stuck-at-0
        run(1'b0, 4'b1110, 17, -1);   // OR device, start re-pulsed mid-run
        run(1'b0, 4'b1000, -1, -1);   // restart from DONE, device fixed
        run(1'b1, 4'b0111, -1, -1);   // NAND, HOLD=1
        run(1'b1, 4'b1000, 2, -1);    // HOLD=1, restart pulse mid-run
        run(1'b0, 4'b1000, -1, 24);   // async reset during vector 2
        run(1'b0, 4'b1000, 39, -1);   // full run after reset, pulse on last edge

        for (int r = 0; r < 10; r++) begin
            s_r = $urandom_range(0, 1);
            h_r = (s_r != 0) ? 1 : 10;
            mid = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 4 * h_r - 1) : -1;
            run(s_r[0], 4'($urandom_range(0, 15)), mid, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
